// File: rtl/card_payment_terminal.sv
// Card payment terminal: payment-side responder for the vending controller's
// COST/VALID_TRAN handshake. Holds the inserted card's balance, charges the
// requested price and answers with an approval or a decline. If the controller
// never vends, the charge is refunded.
//
// Ports
//   CLK, RESET    clock (rising edge), synchronous active-high reset
//   CARD_DETECT   card physically present
//   CARD_LOAD     one-cycle pulse, CARD_BALANCE valid
//   CARD_BALANCE  balance read from the card
//   COST          price code, 0 = no request, 1..6 = request
//   VEND          controller is vending
//   FAILED_TRAN   controller aborted the transaction
//   CARD_IN       card with a loaded balance present
//   VALID_TRAN    one-cycle pulse, charge approved and deducted
//   DECLINED      one-cycle pulse, insufficient balance
//   REFUND        one-cycle pulse, charge returned to the balance
//   BUSY          transaction in flight
//   BALANCE       current balance
module card_payment_terminal #(
  parameter int unsigned BAL_W        = 8,
  parameter int unsigned PRICE_UNIT   = 1,
  parameter int unsigned PROC_LAT     = 2,
  parameter int unsigned VEND_TIMEOUT = 8
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic             CARD_DETECT,
  input  logic             CARD_LOAD,
  input  logic [BAL_W-1:0] CARD_BALANCE,
  input  logic [2:0]       COST,
  input  logic             VEND,
  input  logic             FAILED_TRAN,
  output logic             CARD_IN,
  output logic             VALID_TRAN,
  output logic             DECLINED,
  output logic             REFUND,
  output logic             BUSY,
  output logic [BAL_W-1:0] BALANCE
);

  // One shared counter covers both the processing delay and the vend timeout.
  localparam int unsigned MAX_CNT = (VEND_TIMEOUT > PROC_LAT) ? VEND_TIMEOUT : PROC_LAT;
  localparam int unsigned CNT_W   = (MAX_CNT > 1) ? $clog2(MAX_CNT) : 1;

  localparam logic [CNT_W-1:0] PROC_LAST = CNT_W'(PROC_LAT - 1);
  localparam logic [CNT_W-1:0] VEND_LAST = CNT_W'(VEND_TIMEOUT - 1);
  localparam logic [BAL_W-1:0] UNIT      = BAL_W'(PRICE_UNIT);

  typedef enum logic [2:0] {
    S_NO_CARD,
    S_READY,
    S_PROCESS,
    S_WAIT_VEND,
    S_VEND_HOLD,
    S_DECLINE_HOLD
  } state_t;

  state_t           state, state_n;
  logic [CNT_W-1:0] cnt, cnt_n;
  logic [BAL_W-1:0] chg, chg_n;
  logic [BAL_W-1:0] balance_n;
  logic             valid_n, declined_n, refund_n, card_in_n, busy_n;
  logic [BAL_W-1:0] chg_req;

  assign chg_req = BAL_W'(COST) * UNIT;

  // Next-state, next-balance and next-output logic.
  always_comb begin
    state_n    = state;
    cnt_n      = cnt;
    chg_n      = chg;
    balance_n  = BALANCE;
    valid_n    = 1'b0;
    declined_n = 1'b0;
    refund_n   = 1'b0;

    // Card removal overrides everything; a committed charge is not returned.
    if (state != S_NO_CARD && !CARD_DETECT) begin
      state_n   = S_NO_CARD;
      balance_n = '0;
      cnt_n     = '0;
    end else begin
      unique case (state)
        S_NO_CARD: begin
          if (CARD_DETECT && CARD_LOAD) begin
            balance_n = CARD_BALANCE;
            state_n   = S_READY;
          end
        end

        S_READY: begin
          if (COST != 3'd0) begin
            chg_n   = chg_req;
            cnt_n   = '0;
            state_n = S_PROCESS;
          end
        end

        S_PROCESS: begin
          cnt_n = cnt + CNT_W'(1);
          if (COST == 3'd0) begin
            // Request withdrawn before the decision: drop it silently.
            cnt_n   = '0;
            state_n = S_READY;
          end else if (cnt == PROC_LAST) begin
            if (BALANCE >= chg) begin
              balance_n = BALANCE - chg;
              valid_n   = 1'b1;
              cnt_n     = '0;
              state_n   = S_WAIT_VEND;
            end else begin
              declined_n = 1'b1;
              state_n    = S_DECLINE_HOLD;
            end
          end
        end

        S_WAIT_VEND: begin
          cnt_n = cnt + CNT_W'(1);
          if (VEND) begin
            state_n = S_VEND_HOLD;
          end else if (FAILED_TRAN || cnt == VEND_LAST) begin
            balance_n = BALANCE + chg;
            refund_n  = 1'b1;
            cnt_n     = '0;
            state_n   = S_READY;
          end
        end

        // Wait for the controller to release VEND and COST so a stale
        // request is not charged twice.
        S_VEND_HOLD: begin
          if (!VEND && COST == 3'd0) begin
            state_n = S_READY;
          end
        end

        // A declined request is never re-evaluated while COST is held.
        S_DECLINE_HOLD: begin
          if (COST == 3'd0) begin
            state_n = S_READY;
          end
        end

        default: begin
          state_n   = S_NO_CARD;
          balance_n = '0;
          cnt_n     = '0;
        end
      endcase
    end

    card_in_n = (state_n != S_NO_CARD);
    busy_n    = (state_n == S_PROCESS)   || (state_n == S_WAIT_VEND) ||
                (state_n == S_VEND_HOLD) || (state_n == S_DECLINE_HOLD);
  end

  // State, datapath and registered outputs.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      state      <= S_NO_CARD;
      cnt        <= '0;
      chg        <= '0;
      BALANCE    <= '0;
      CARD_IN    <= 1'b0;
      VALID_TRAN <= 1'b0;
      DECLINED   <= 1'b0;
      REFUND     <= 1'b0;
      BUSY       <= 1'b0;
    end else begin
      state      <= state_n;
      cnt        <= cnt_n;
      chg        <= chg_n;
      BALANCE    <= balance_n;
      CARD_IN    <= card_in_n;
      VALID_TRAN <= valid_n;
      DECLINED   <= declined_n;
      REFUND     <= refund_n;
      BUSY       <= busy_n;
    end
  end

endmodule

// File: tb/tb_card_payment_terminal.sv
// Testbench for card_payment_terminal. Expected result pulses (kind, cycle,
// balance) are queued when a request is driven and compared by a monitor
// when the terminal pulses VALID_TRAN, DECLINED or REFUND.
module tb_card_payment_terminal;

  localparam logic [2:0] K_VALID = 3'b100;
  localparam logic [2:0] K_DECL  = 3'b010;
  localparam logic [2:0] K_REF   = 3'b001;

  logic       CLK = 1'b0;
  logic       RESET = 1'b1;
  logic       CARD_DETECT = 1'b0;
  logic       CARD_LOAD = 1'b0;
  logic [7:0] CARD_BALANCE = 8'd0;
  logic [2:0] COST = 3'd0;
  logic       VEND = 1'b0;
  logic       FAILED_TRAN = 1'b0;
  logic       CARD_IN, VALID_TRAN, DECLINED, REFUND, BUSY;
  logic [7:0] BALANCE;

  card_payment_terminal dut (
    .CLK(CLK), .RESET(RESET), .CARD_DETECT(CARD_DETECT), .CARD_LOAD(CARD_LOAD),
    .CARD_BALANCE(CARD_BALANCE), .COST(COST), .VEND(VEND), .FAILED_TRAN(FAILED_TRAN),
    .CARD_IN(CARD_IN), .VALID_TRAN(VALID_TRAN), .DECLINED(DECLINED), .REFUND(REFUND),
    .BUSY(BUSY), .BALANCE(BALANCE)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic [2:0] kind;
    int         cyc;
    logic [7:0] bal;
  } exp_t;

  exp_t sb[$];
  int   cyc = 0;
  int   checks = 0;
  int   failures = 0;

  always @(posedge CLK) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Scoreboard monitor: every result pulse must match the head of the queue.
  always @(negedge CLK) begin
    exp_t e;
    if (VALID_TRAN || DECLINED || REFUND) begin
      if (sb.size() == 0) begin
        check("unexpected_pulse", 32'({VALID_TRAN, DECLINED, REFUND}), 32'd0);
      end else begin
        e = sb.pop_front();
        check("pulse_kind", 32'({VALID_TRAN, DECLINED, REFUND}), 32'(e.kind));
        check("pulse_cycle", 32'(cyc), 32'(e.cyc));
        check("pulse_balance", 32'(BALANCE), 32'(e.bal));
      end
    end else if (sb.size() != 0 && sb[0].cyc <= cyc) begin
      e = sb.pop_front();
      check("missed_pulse", 32'd0, 32'(e.kind));
    end
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge CLK);
      #1;
    end
  endtask

  task automatic expect_pulse(input logic [2:0] kind, input int dly, input logic [7:0] bal);
    sb.push_back('{kind: kind, cyc: cyc + dly, bal: bal});
  endtask

  // Bounded wait until the scoreboard has drained down to 'left' entries.
  task automatic wait_sb(input string tag, input int left, input int budget);
    int n = 0;
    while (sb.size() > left && n < budget) begin
      tick(1);
      n++;
    end
    check(tag, 32'(sb.size()), 32'(left));
  endtask

  task automatic load_card(input logic [7:0] b);
    CARD_DETECT = 1'b0;
    tick(1);
    CARD_DETECT  = 1'b1;
    CARD_LOAD    = 1'b1;
    CARD_BALANCE = b;
    tick(1);
    CARD_LOAD = 1'b0;
    check("load_card_in", 32'(CARD_IN), 32'd1);
    check("load_balance", 32'(BALANCE), 32'(b));
  endtask

  task automatic check_idle_outputs(input string tag);
    check(tag, 32'({CARD_IN, VALID_TRAN, DECLINED, REFUND, BUSY, BALANCE}), 32'd0);
  endtask

  initial begin
    // 1. Reset and card insertion.
    RESET = 1'b1;
    tick(2);
    check_idle_outputs("reset_outputs");
    RESET = 1'b0;
    tick(1);
    load_card(8'd20);
    check("ready_busy", 32'(BUSY), 32'd0);

    // 2. Approval after PROC_LAT+1 cycles; stale COST held through vend.
    expect_pulse(K_VALID, 3, 8'd15);
    COST = 3'd5;
    tick(1);
    check("process_busy", 32'(BUSY), 32'd1);
    wait_sb("approve_timeout", 0, 10);
    VEND = 1'b1;
    tick(1);
    VEND = 1'b0;
    tick(4);
    check("vend_hold_busy", 32'(BUSY), 32'd1);
    check("vend_hold_balance", 32'(BALANCE), 32'd15);
    COST = 3'd0;
    tick(1);
    check("vend_done_busy", 32'(BUSY), 32'd0);

    // 3. Decline, held COST not re-evaluated; then exact-balance approval.
    load_card(8'd3);
    expect_pulse(K_DECL, 3, 8'd3);
    COST = 3'd4;
    wait_sb("decline_timeout", 0, 10);
    tick(5);
    check("decline_hold_busy", 32'(BUSY), 32'd1);
    check("decline_balance", 32'(BALANCE), 32'd3);
    COST = 3'd0;
    tick(1);
    check("decline_release_busy", 32'(BUSY), 32'd0);
    expect_pulse(K_VALID, 3, 8'd0);
    COST = 3'd3;
    wait_sb("exact_timeout", 0, 10);
    COST = 3'd0;
    VEND = 1'b1;
    tick(1);
    VEND = 1'b0;
    tick(1);
    check("exact_balance", 32'(BALANCE), 32'd0);
    check("exact_busy", 32'(BUSY), 32'd0);

    // 4. No VEND: refund after the timeout, 11 cycles after the request.
    load_card(8'd10);
    expect_pulse(K_VALID, 3, 8'd4);
    expect_pulse(K_REF, 11, 8'd10);
    COST = 3'd6;
    wait_sb("timeout_approve", 1, 10);
    COST = 3'd0;
    wait_sb("timeout_refund", 0, 20);
    check("timeout_card_in", 32'(CARD_IN), 32'd1);
    check("timeout_balance", 32'(BALANCE), 32'd10);
    tick(1);
    check("timeout_busy", 32'(BUSY), 32'd0);

    // 5a. FAILED_TRAN in WAIT_VEND refunds.
    expect_pulse(K_VALID, 3, 8'd8);
    COST = 3'd2;
    wait_sb("failed_approve", 0, 10);
    COST = 3'd0;
    expect_pulse(K_REF, 1, 8'd10);
    FAILED_TRAN = 1'b1;
    tick(1);
    FAILED_TRAN = 1'b0;
    wait_sb("failed_refund", 0, 5);

    // 5b. VEND beats FAILED_TRAN in the same cycle: no refund.
    expect_pulse(K_VALID, 3, 8'd8);
    COST = 3'd2;
    wait_sb("both_approve", 0, 10);
    COST = 3'd0;
    VEND = 1'b1;
    FAILED_TRAN = 1'b1;
    tick(1);
    VEND = 1'b0;
    FAILED_TRAN = 1'b0;
    tick(12);
    check("both_balance", 32'(BALANCE), 32'd8);
    check("both_busy", 32'(BUSY), 32'd0);

    // 6a. Card pulled on the decision cycle of PROCESS: no charge, no pulse.
    COST = 3'd3;
    tick(2);
    CARD_DETECT = 1'b0;
    tick(1);
    check("pull_card_in", 32'(CARD_IN), 32'd0);
    check("pull_balance", 32'(BALANCE), 32'd0);
    check("pull_busy", 32'(BUSY), 32'd0);
    tick(4);
    COST = 3'd0;

    // 6b. Card pulled in WAIT_VEND: no refund.
    load_card(8'd10);
    expect_pulse(K_VALID, 3, 8'd8);
    COST = 3'd2;
    wait_sb("pullwv_approve", 0, 10);
    COST = 3'd0;
    CARD_DETECT = 1'b0;
    tick(1);
    check("pullwv_balance", 32'(BALANCE), 32'd0);
    check("pullwv_card_in", 32'(CARD_IN), 32'd0);
    tick(10);

    // 6c. RESET in WAIT_VEND clears all outputs on the next cycle.
    load_card(8'd10);
    expect_pulse(K_VALID, 3, 8'd8);
    COST = 3'd2;
    wait_sb("reset_approve", 0, 10);
    COST = 3'd0;
    tick(2);
    RESET = 1'b1;
    tick(1);
    check_idle_outputs("midreset_outputs");
    RESET = 1'b0;
    tick(12);
    check("sb_empty", 32'(sb.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
